// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ADD/SUB/AND/OR/LT, iterative signed MUL/DIV/MOD.
// Define ALU_DIV_EN to build the divider; without it DIV/MOD finish in one clock with err set.
module alu_seq #(
  parameter int N    = 8,
  parameter int CS_N = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    data_a,
  input  logic [N-1:0]    data_b,
  input  logic            carry_in,
  input  logic [CS_N-1:0] CS,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    S,
  output logic [N-1:0]    R,
  output logic            zero,
  output logic            carry_out,
  output logic            ovf,
  output logic            err,
  output logic [1:0]      dbg_state_o
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [CS_N-1:0] OP_ADD = CS_N'(0);
  localparam logic [CS_N-1:0] OP_SUB = CS_N'(1);
  localparam logic [CS_N-1:0] OP_AND = CS_N'(2);
  localparam logic [CS_N-1:0] OP_OR  = CS_N'(3);
  localparam logic [CS_N-1:0] OP_LT  = CS_N'(4);
  localparam logic [CS_N-1:0] OP_MUL = CS_N'(5);
  localparam logic [CS_N-1:0] OP_DIV = CS_N'(6);
  localparam logic [CS_N-1:0] OP_MOD = CS_N'(7);

  localparam logic [N-1:0]   ONE_N  = N'(1);
  localparam logic [2*N-1:0] ONE_2N = (2*N)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2} state_t;

  // Handshake: a port transfers on a rising edge where its valid and ready are both high;
  // valid, once raised, holds with its payload until the transfer.
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CS_N-1:0] op_q, op_d;
  logic            neg_q, neg_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [N-1:0]    m_q, m_d;
  logic            ov_q, ov_d;
  logic [N-1:0]    s_q, s_d, r_q, r_d;
  logic            zero_q, zero_d, c_q, c_d, ovf_q, ovf_d, err_q, err_d;

  logic            accept, load;
  logic [N-1:0]    res_s, res_r;
  logic            res_c, res_o, res_e;
  logic [N-1:0]    mag_a, mag_b;
  logic [N:0]      usum, udiff;
  logic [N+1:0]    add_w, sub_w;
  logic            add_ovf, sub_ovf;
  logic [N:0]      msum;
  logic [2*N-1:0]  mul_step, prod;

  assign mag_a = data_a[N-1] ? (~data_a + ONE_N) : data_a;
  assign mag_b = data_b[N-1] ? (~data_b + ONE_N) : data_b;

  assign usum  = {1'b0, data_a} + {1'b0, data_b} + {{N{1'b0}}, carry_in};
  assign udiff = {1'b0, data_a} - {1'b0, data_b} + {{N{1'b0}}, carry_in};

  // Signed overflow: the exact N+2-bit signed result must sign-extend from bit N-1.
  assign add_w   = {{2{data_a[N-1]}}, data_a} + {{2{data_b[N-1]}}, data_b} + {{(N+1){1'b0}}, carry_in};
  assign sub_w   = {{2{data_a[N-1]}}, data_a} - {{2{data_b[N-1]}}, data_b} + {{(N+1){1'b0}}, carry_in};
  assign add_ovf = !((add_w[N+1] == add_w[N]) && (add_w[N] == add_w[N-1]));
  assign sub_ovf = !((sub_w[N+1] == sub_w[N]) && (sub_w[N] == sub_w[N-1]));

  // Shift-add on magnitudes: acc holds {partial high word, remaining multiplier bits}.
  assign msum     = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, m_q} : {(N+1){1'b0}});
  assign mul_step = {msum, acc_q[N-1:1]};
  assign prod     = neg_q ? (~acc_q + ONE_2N) : acc_q;

`ifdef ALU_DIV_EN
  logic            rneg_q, rneg_d;
  logic [N:0]      shifted;
  logic [N+1:0]    trial;
  logic [N-1:0]    new_rem, q_mag, r_mag, q_val, r_val;
  logic [2*N-1:0]  div_step;

  // Restoring division: acc holds {remainder, dividend bits shifting into quotient}.
  assign shifted  = {acc_q[2*N-1:N], acc_q[N-1]};
  assign trial    = {1'b0, shifted} - {2'b00, m_q};
  assign new_rem  = trial[N+1] ? shifted[N-1:0] : trial[N-1:0];
  assign div_step = {new_rem, acc_q[N-2:0], ~trial[N+1]};
  assign q_mag    = acc_q[N-1:0];
  assign r_mag    = acc_q[2*N-1:N];
  assign q_val    = neg_q  ? (~q_mag + ONE_N) : q_mag;
  assign r_val    = rneg_q ? (~r_mag + ONE_N) : r_mag;
`endif

  assign in_ready = (state_q == IDLE) && (!ov_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    m_d     = m_q;
`ifdef ALU_DIV_EN
    rneg_d  = rneg_q;
`endif
    load    = 1'b0;
    res_s   = '0;
    res_r   = '0;
    res_c   = 1'b0;
    res_o   = 1'b0;
    res_e   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = CS;
          case (CS)
            OP_ADD: begin load = 1'b1; res_s = usum[N-1:0];  res_c = usum[N];  res_o = add_ovf; end
            OP_SUB: begin load = 1'b1; res_s = udiff[N-1:0]; res_c = udiff[N]; res_o = sub_ovf; end
            OP_AND: begin load = 1'b1; res_s = data_a & data_b; end
            OP_OR:  begin load = 1'b1; res_s = data_a | data_b; end
            OP_LT:  begin load = 1'b1; res_s = ($signed(data_a) < $signed(data_b)) ? ONE_N : '0; end
            OP_MUL: begin
              state_d = ITER;
              cnt_d   = CW'(N - 1);
              acc_d   = {{N{1'b0}}, mag_b};
              m_d     = mag_a;
              neg_d   = data_a[N-1] ^ data_b[N-1];
            end
            OP_DIV, OP_MOD: begin
`ifdef ALU_DIV_EN
              if (data_b == '0) begin
                load  = 1'b1;
                res_s = '1;
                res_r = data_a;
                res_e = 1'b1;
              end else begin
                state_d = ITER;
                cnt_d   = CW'(N - 1);
                acc_d   = {{N{1'b0}}, mag_a};
                m_d     = mag_b;
                neg_d   = data_a[N-1] ^ data_b[N-1];
                rneg_d  = data_a[N-1];
              end
`else
              load  = 1'b1;
              res_e = 1'b1;
`endif
            end
            default: ;
          endcase
        end
      end
      ITER: begin
        acc_d = mul_step;
`ifdef ALU_DIV_EN
        if (op_q != OP_MUL) acc_d = div_step;
`endif
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        load    = 1'b1;
        res_s   = prod[N-1:0];
        res_r   = prod[2*N-1:N];
        // Product fits in N signed bits only if the top N+1 bits are all equal.
        res_o   = !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1]));
`ifdef ALU_DIV_EN
        if (op_q != OP_MUL) begin
          res_s = (op_q == OP_MOD) ? r_val : q_val;
          res_r = (op_q == OP_MOD) ? q_val : r_val;
          // Only -2^(N-1) / -1 yields a positive quotient with the top magnitude bit set.
          res_o = !neg_q && q_mag[N-1];
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ov_d   = out_ready ? 1'b0 : ov_q;
    s_d    = s_q;
    r_d    = r_q;
    zero_d = zero_q;
    c_d    = c_q;
    ovf_d  = ovf_q;
    err_d  = err_q;
    if (load) begin
      ov_d   = 1'b1;
      s_d    = res_s;
      r_d    = res_r;
      zero_d = (res_s == '0);
      c_d    = res_c;
      ovf_d  = res_o;
      err_d  = res_e;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      m_q     <= '0;
`ifdef ALU_DIV_EN
      rneg_q  <= 1'b0;
`endif
      ov_q    <= 1'b0;
      s_q     <= '0;
      r_q     <= '0;
      zero_q  <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
`ifdef ALU_DIV_EN
      rneg_q  <= rneg_d;
`endif
      ov_q    <= ov_d;
      s_q     <= s_d;
      r_q     <= r_d;
      zero_q  <= zero_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign out_valid   = ov_q;
  assign S           = s_q;
  assign R           = r_q;
  assign zero        = zero_q;
  assign carry_out   = c_q;
  assign ovf         = ovf_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=8): scoreboard queue of expected results, decoupled monitor.
module tb_alu_seq;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_LT  = 3'd4, OP_MUL = 3'd5, OP_DIV = 3'd6, OP_MOD = 3'd7;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_ready;
  logic [7:0] data_a = '0, data_b = '0;
  logic       carry_in = 1'b0;
  logic [2:0] CS = '0;
  logic       out_valid, out_ready = 1'b1;
  logic [7:0] S, R;
  logic       zero, carry_out, ovf, err;
  logic [1:0] dbg_state;

  int n_total = 0, n_bad = 0;
  int cyc = 0, acc_cyc = 0, pop_cyc = 0, t0 = 0;
  logic [19:0] exp_q[$];

  alu_seq #(.N(8), .CS_N(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b), .carry_in(carry_in), .CS(CS),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .R(R),
    .zero(zero), .carry_out(carry_out), .ovf(ovf), .err(err),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // {S, R, zero, carry_out, ovf, err}
  function automatic logic [19:0] ex(input logic [7:0] s, input logic [7:0] r,
                                     input logic c, input logic o, input logic e);
    return {s, r, (s == 8'h00), c, o, e};
  endfunction

  // Scoreboard monitor: a result is taken when out_valid && out_ready at the coming edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pop_cyc = cyc + 1;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {12'h0, S, R, zero, carry_out, ovf, err}, 32'hFFFF_FFFF);
      end else begin
        chk("result", {S, R, zero, carry_out, ovf, err}, exp_q.pop_front());
      end
    end
  end

  // Drivers
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [19:0] e);
    int n;
    data_a = a; data_b = b; CS = op; carry_in = cin; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", in_ready, 1);
    if (in_ready) begin
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      acc_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_lat(input string nm, input int lat);
    int n, busy;
    n = 0; busy = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) busy++;
      @(posedge clk); #1;
      n++;
    end
    chk(nm, n, lat);
    chk("busy_in_ready_low", busy, 0);
  endtask

  task automatic op_lat(input string nm, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input logic [19:0] e, input int lat);
    send(op, a, b, cin, e);
    wait_lat(nm, lat);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_SR", {S, R}, 0);
    chk("rst_flags", {zero, carry_out, ovf, err}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state", dbg_state, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops: result visible right after the accept edge
    op_lat("add_lat", OP_ADD, 8'h7F, 8'h01, 1'b0, ex(8'h80, 8'h00, 1'b0, 1'b1, 1'b0), 0);
    op_lat("add_lat", OP_ADD, 8'hFF, 8'h01, 1'b0, ex(8'h00, 8'h00, 1'b1, 1'b0, 1'b0), 0);
    op_lat("add_lat", OP_ADD, 8'h05, 8'h03, 1'b1, ex(8'h09, 8'h00, 1'b0, 1'b0, 1'b0), 0);
    op_lat("sub_lat", OP_SUB, 8'h05, 8'h07, 1'b0, ex(8'hFE, 8'h00, 1'b1, 1'b0, 1'b0), 0);
    op_lat("sub_lat", OP_SUB, 8'h80, 8'h01, 1'b0, ex(8'h7F, 8'h00, 1'b0, 1'b1, 1'b0), 0);
    op_lat("and_lat", OP_AND, 8'hF0, 8'h3C, 1'b0, ex(8'h30, 8'h00, 1'b0, 1'b0, 1'b0), 0);
    op_lat("or_lat",  OP_OR,  8'hF0, 8'h0F, 1'b0, ex(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0), 0);
    op_lat("lt_lat",  OP_LT,  8'hFF, 8'h01, 1'b0, ex(8'h01, 8'h00, 1'b0, 1'b0, 1'b0), 0);
    op_lat("lt_lat",  OP_LT,  8'h05, 8'h03, 1'b0, ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b0), 0);

    // Multiply: N ITER + 1 FIX edges after accept
    op_lat("mul_lat", OP_MUL, 8'hFD, 8'h05, 1'b0, ex(8'hF1, 8'hFF, 1'b0, 1'b0, 1'b0), 9);
    op_lat("mul_lat", OP_MUL, 8'h10, 8'h10, 1'b0, ex(8'h00, 8'h01, 1'b0, 1'b1, 1'b0), 9);
    op_lat("mul_lat", OP_MUL, 8'h80, 8'h80, 1'b0, ex(8'h00, 8'h40, 1'b0, 1'b1, 1'b0), 9);
    op_lat("mul_lat", OP_MUL, 8'h7F, 8'hFF, 1'b0, ex(8'h81, 8'hFF, 1'b0, 1'b0, 1'b0), 9);

`ifdef ALU_DIV_EN
    op_lat("div_lat", OP_DIV, 8'hF9, 8'h02, 1'b0, ex(8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0), 9);
    op_lat("mod_lat", OP_MOD, 8'hF9, 8'h02, 1'b0, ex(8'hFF, 8'hFD, 1'b0, 1'b0, 1'b0), 9);
    op_lat("div_lat", OP_DIV, 8'h80, 8'hFF, 1'b0, ex(8'h80, 8'h00, 1'b0, 1'b1, 1'b0), 9);
    op_lat("mod_lat", OP_MOD, 8'h07, 8'hFE, 1'b0, ex(8'h01, 8'hFD, 1'b0, 1'b0, 1'b0), 9);
    op_lat("div0_lat", OP_DIV, 8'h05, 8'h00, 1'b0, ex(8'hFF, 8'h05, 1'b0, 1'b0, 1'b1), 0);
    op_lat("mod0_lat", OP_MOD, 8'h80, 8'h00, 1'b0, ex(8'hFF, 8'h80, 1'b0, 1'b0, 1'b1), 0);
`else
    op_lat("div_lat", OP_DIV, 8'hF9, 8'h02, 1'b0, ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b1), 0);
    op_lat("mod_lat", OP_MOD, 8'hF9, 8'h02, 1'b0, ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b1), 0);
    op_lat("div0_lat", OP_DIV, 8'h05, 8'h00, 1'b0, ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b1), 0);
`endif

    // Back-to-back single-cycle ops: one accept per clock
    send(OP_ADD, 8'h01, 8'h01, 1'b0, ex(8'h02, 8'h00, 1'b0, 1'b0, 1'b0));
    t0 = acc_cyc;
    send(OP_SUB, 8'h09, 8'h04, 1'b0, ex(8'h05, 8'h00, 1'b0, 1'b0, 1'b0));
    chk("throughput", acc_cyc - t0, 1);
    t0 = acc_cyc;
    send(OP_AND, 8'hFF, 8'h0F, 1'b0, ex(8'h0F, 8'h00, 1'b0, 1'b0, 1'b0));
    send(OP_OR,  8'h00, 8'h00, 1'b0, ex(8'h00, 8'h00, 1'b0, 1'b0, 1'b0));
    chk("throughput", acc_cyc - t0, 2);
    @(posedge clk); #1;

    // Backpressure: result held while out_ready is low
    out_ready = 1'b0;
    send(OP_ADD, 8'h02, 8'h02, 1'b0, ex(8'h04, 8'h00, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_SR", {S, R}, 16'h0400);
      chk("hold_flags", {zero, carry_out, ovf, err}, 4'b0000);
      chk("hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(OP_OR, 8'h30, 8'h03, 1'b0, ex(8'h33, 8'h00, 1'b0, 1'b0, 1'b0));
    chk("accept_on_consume", acc_cyc, pop_cyc);
    @(posedge clk); #1;

    // Reset during MUL iteration
    send(OP_MUL, 8'hFD, 8'h05, 1'b0, ex(8'hF1, 8'hFF, 1'b0, 1'b0, 1'b0));
    repeat (4) @(posedge clk);
    #1;
    chk("mid_state_iter", dbg_state, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_SR", {S, R}, 0);
    chk("midrst_flags", {zero, carry_out, ovf, err}, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_state", dbg_state, 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    op_lat("post_rst_add", OP_ADD, 8'h02, 8'h03, 1'b0, ex(8'h05, 8'h00, 1'b0, 1'b0, 1'b0), 0);

    repeat (12) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
